// File: rtl/input_port_vc_buffer_if.sv
// Link-side bundle of the input-port VC buffer: upstream flit push, per-VC heads,
// switch pop requests and the credit return path.
interface input_port_vc_buffer_if #(
  parameter int unsigned VC_NUM      = 4,
  parameter int unsigned FLIT_DATA_W = 64,
  parameter int unsigned VC_ID_W     = 3,
  parameter int unsigned ROUTE_W     = 5   // width of io_port_t
);
  logic                                  flit_vld_i;
  logic [VC_ID_W-1:0]                    flit_vc_id_i;
  logic [FLIT_DATA_W-1:0]                flit_data_i;
  logic [ROUTE_W-1:0]                    flit_look_ahead_routing_i;
  logic [VC_NUM-1:0]                     pop_i;
  logic [VC_NUM-1:0]                     head_vld_o;
  logic [VC_NUM-1:0][FLIT_DATA_W-1:0]    head_data_o;
  logic [VC_NUM-1:0][ROUTE_W-1:0]        head_look_ahead_routing_o;
  logic                                  credit_vld_o;
  logic [VC_ID_W-1:0]                    credit_vc_id_o;
  logic                                  err_o;

  modport master (
    output flit_vld_i, flit_vc_id_i, flit_data_i, flit_look_ahead_routing_i, pop_i,
    input  head_vld_o, head_data_o, head_look_ahead_routing_o,
    input  credit_vld_o, credit_vc_id_o, err_o
  );

  modport slave (
    input  flit_vld_i, flit_vc_id_i, flit_data_i, flit_look_ahead_routing_i, pop_i,
    output head_vld_o, head_data_o, head_look_ahead_routing_o,
    output credit_vld_o, credit_vc_id_o, err_o
  );
endinterface

// File: rtl/input_port_vc_buffer.sv
// Router input port: one circular FIFO per virtual channel, registered credit return
// on every accepted pop, and a sticky protocol-error flag.
module input_port_vc_buffer #(
  parameter int unsigned VC_NUM      = 4,
  parameter int unsigned VC_DEPTH    = 4,
  parameter int unsigned FLIT_DATA_W = 64,
  parameter int unsigned VC_ID_W     = 3,
  parameter int unsigned ROUTE_W     = 5
) (
  input logic                   clk,
  input logic                   rst,
  input_port_vc_buffer_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(VC_DEPTH);
  localparam int unsigned CNT_W = $clog2(VC_DEPTH + 1);

  logic [FLIT_DATA_W-1:0] r_data  [VC_NUM][VC_DEPTH];
  logic [ROUTE_W-1:0]     r_route [VC_NUM][VC_DEPTH];
  logic [PTR_W-1:0]       r_rd_ptr [VC_NUM];
  logic [PTR_W-1:0]       r_wr_ptr [VC_NUM];
  logic [CNT_W-1:0]       r_cnt    [VC_NUM];
  logic                   r_credit_vld;
  logic [VC_ID_W-1:0]     r_credit_id;
  logic                   r_err;

  logic [VC_NUM-1:0]      w_pop_sel;
  logic [VC_NUM-1:0]      w_pop_hit;
  logic [VC_NUM-1:0]      w_push_req;
  logic [VC_NUM-1:0]      w_push_hit;
  logic [VC_NUM-1:0]      w_full;
  logic [VC_ID_W-1:0]     w_pop_idx;
  logic                   w_pop_ok;
  logic                   w_pop_multi;
  logic                   w_err;

  always_comb begin
    // Isolate the lowest set pop bit; any extra bits are a protocol error.
    w_pop_sel   = bus.pop_i & (~bus.pop_i + VC_NUM'(1));
    w_pop_multi = (bus.pop_i & (bus.pop_i - VC_NUM'(1))) != '0;
    w_pop_idx   = '0;
    w_err       = 1'b0;
    w_full      = '0;
    w_pop_hit   = '0;
    w_push_req  = '0;
    w_push_hit  = '0;
    for (int v = VC_NUM - 1; v >= 0; v--) begin
      if (bus.pop_i[v]) w_pop_idx = VC_ID_W'(v);
    end
    for (int v = 0; v < VC_NUM; v++) begin
      w_full[v]     = r_cnt[v] == CNT_W'(VC_DEPTH);
      w_pop_hit[v]  = w_pop_sel[v] && (r_cnt[v] != '0);
      w_push_req[v] = bus.flit_vld_i && (bus.flit_vc_id_i == VC_ID_W'(v));
      // A full VC still accepts when the same VC is popped in this cycle.
      w_push_hit[v] = w_push_req[v] && (!w_full[v] || w_pop_hit[v]);
      if (w_push_req[v] && !w_push_hit[v]) w_err = 1'b1;
      if (w_pop_sel[v] && !w_pop_hit[v])   w_err = 1'b1;
    end
    w_pop_ok = |w_pop_hit;
    if (bus.flit_vld_i && (32'(bus.flit_vc_id_i) >= VC_NUM)) w_err = 1'b1;
    if (w_pop_multi) w_err = 1'b1;
  end

  always_ff @(posedge clk) begin
    for (int v = 0; v < VC_NUM; v++) begin
      if (w_push_hit[v]) begin
        r_data[v][r_wr_ptr[v]]  <= bus.flit_data_i;
        r_route[v][r_wr_ptr[v]] <= bus.flit_look_ahead_routing_i;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < VC_NUM; v++) begin
        r_rd_ptr[v] <= '0;
        r_wr_ptr[v] <= '0;
        r_cnt[v]    <= '0;
      end
      r_credit_vld <= 1'b0;
      r_credit_id  <= '0;
      r_err        <= 1'b0;
    end else begin
      for (int v = 0; v < VC_NUM; v++) begin
        if (w_push_hit[v]) r_wr_ptr[v] <= r_wr_ptr[v] + PTR_W'(1);
        if (w_pop_hit[v])  r_rd_ptr[v] <= r_rd_ptr[v] + PTR_W'(1);
        if (w_push_hit[v] && !w_pop_hit[v]) begin
          r_cnt[v] <= r_cnt[v] + CNT_W'(1);
        end else if (w_pop_hit[v] && !w_push_hit[v]) begin
          r_cnt[v] <= r_cnt[v] - CNT_W'(1);
        end
      end
      r_credit_vld <= w_pop_ok;
      if (w_pop_ok) r_credit_id <= w_pop_idx;
      if (w_err)    r_err       <= 1'b1;
    end
  end

  always_comb begin
    for (int v = 0; v < VC_NUM; v++) begin
      bus.head_vld_o[v]                = r_cnt[v] != '0;
      bus.head_data_o[v]               = r_data[v][r_rd_ptr[v]];
      bus.head_look_ahead_routing_o[v] = r_route[v][r_rd_ptr[v]];
    end
  end

  assign bus.credit_vld_o   = r_credit_vld;
  assign bus.credit_vc_id_o = r_credit_id;
  assign bus.err_o          = r_err;

endmodule

// File: doc/input_port_vc_buffer.md
INPUT_PORT_VC_BUFFER -- requirements
Module: input_port_vc_buffer

Interface
REQ-001 Parameter VC_NUM, default 4: number of virtual channels on this input port.
REQ-002 Parameter VC_DEPTH, default 4: flit slots per VC, which equals the upstream credit count per VC; power of two and at least 2.
REQ-003 Parameter FLIT_DATA_W, default 64: flit payload width.
REQ-004 Parameter VC_ID_W, default VC_ID_NUM_MAX_W: width of the VC id field.
REQ-005 clk  input  1  single clock for the whole block.
REQ-006 rst  input  1  reset, asynchronous and active-high.
REQ-007 flit_vld_i  input  1  flit arriving from the upstream link.
REQ-008 flit_vc_id_i  input  VC_ID_W  VC the upstream output port assigned to this flit.
REQ-009 flit_data_i  input  FLIT_DATA_W  flit payload.
REQ-010 flit_look_ahead_routing_i  input  $bits(io_port_t)  look-ahead route carried with the flit.
REQ-011 pop_i  input  VC_NUM  dequeue request per VC from switch traversal; one-hot or zero.
REQ-012 head_vld_o  output  VC_NUM  the VC holds at least one flit.
REQ-013 head_data_o  output  VC_NUM x FLIT_DATA_W  payload at the head of each VC.
REQ-014 head_look_ahead_routing_o  output  VC_NUM x $bits(io_port_t)  route at the head of each VC.
REQ-015 credit_vld_o  output  1  credit returned upstream.
REQ-016 credit_vc_id_o  output  VC_ID_W  VC the returned credit belongs to.
REQ-017 err_o  output  1  sticky protocol-error flag.

Function
REQ-018 Each VC SHALL be an independent circular FIFO with a read pointer and a write pointer of log2(VC_DEPTH) bits each, plus an occupancy counter of $clog2(VC_DEPTH+1) bits.
- Pointers wrap from VC_DEPTH-1 to 0.
REQ-019 Write: flit_vld_i=1 with flit_vc_id_i<VC_NUM SHALL store the data and route at the write pointer of that VC on the rising edge, then advance the write pointer.
REQ-020 Write-to-read latency SHALL be one cycle.
- No bypass: a flit written at edge t appears on head_* after edge t, never in the same cycle it arrives.
REQ-021 head_vld_o[v] SHALL equal (occupancy[v]!=0).
- head_data_o and head_look_ahead_routing_o SHALL be combinational reads at the read pointer.
- When head_vld_o[v]=0, head_data_o[v] and head_look_ahead_routing_o[v] are don't-care.
REQ-022 Pop: pop_i[v]=1 with occupancy[v]!=0 SHALL advance the read pointer of v and decrement occupancy[v].
REQ-023 Credit return: a pop accepted at edge t SHALL produce credit_vld_o=1 and credit_vc_id_o=v, registered, during the cycle after edge t.
- Otherwise credit_vld_o=0 and credit_vc_id_o holds its last value.
REQ-024 Simultaneous push and pop on the same VC SHALL leave occupancy unchanged and move both pointers.
- This applies when the VC is full (push accepted) and when it holds one flit.
REQ-025 Simultaneous push to one VC and pop from a different VC SHALL each take effect independently.
REQ-026 Push to a full VC without a same-cycle pop to that VC SHALL be dropped, with state unchanged and err_o set.
REQ-027 A push with flit_vc_id_i>=VC_NUM SHALL be dropped and SHALL set err_o.
REQ-028 A pop on an empty VC SHALL be ignored, return no credit, and set err_o.
REQ-029 Multi-hot pop_i: only the lowest set index SHALL be served, and err_o SHALL be set.
REQ-030 err_o SHALL stay at 1 once set and clear only on rst.
REQ-031 Credits returned per VC SHALL equal flits popped per VC; credits are never generated or lost except as defined in REQ-028 and REQ-029.

Reset
REQ-032 While rst=1, asynchronously:
- all pointers and occupancy counters SHALL be 0;
- head_vld_o=0, credit_vld_o=0, credit_vc_id_o=0, err_o=0.
REQ-033 Storage arrays need not be reset.
REQ-034 rst asserted mid-operation SHALL discard all buffered flits.
- No credit SHALL be emitted for the discarded flits; the upstream credit counters reset in the same reset domain.
REQ-035 The first push accepted after rst deasserts SHALL behave as a push into an empty VC.

Verification
REQ-036 Push VC2 data 0xA5 at cycle 0 -> cycle 1: head_vld_o[2]=1, head_data_o[2]=0xA5, all other head_vld_o bits 0.
REQ-037 Pop VC2 at cycle 1 -> cycle 2: head_vld_o[2]=0, credit_vld_o=1, credit_vc_id_o=2; cycle 3: credit_vld_o=0.
REQ-038 Fill VC1 with 4 flits 1..4 (VC_DEPTH=4), then push and pop VC1 in the same cycle with data 5 -> no error, occupancy stays 4, pop order is 2,3,4,5, and 5 credits total are returned for VC1.
REQ-039 Push a 5th flit to a full VC0 with no pop -> flit dropped, err_o=1, later pops return only 4 flits.
REQ-040 pop_i=4'b0110 with VC1 and VC2 non-empty -> only VC1 popped, credit_vc_id_o=1, err_o=1.
REQ-041 Assert rst with 3 flits buffered in VC3 -> head_vld_o=0 immediately, no credit_vld_o pulse; a post-reset push of 0x11 to VC3 is visible at the head of VC3 one cycle later.
